// File: rtl/nec_prefetch_pkg.sv
// nec_prefetch_pkg: shared types and constants for the prefetch queue and nec_decode
package nec_prefetch_pkg;
  localparam int IPQ_DEPTH = 8;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DISCARD} prefetch_state_e;
  function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction
endpackage

// File: rtl/nec_prefetch.sv
// nec_prefetch: instruction prefetch queue, fetches code at ps:fetch_pc into an 8-byte ring
// Ports: clk/reset_n (async low)/ce; ps, flush, flush_pc, consume_pc from the decoder;
//   ipq (ring, entry k = byte with address low bits k), ipq_len (valid bytes from consume_pc);
//   bus_req/bus_addr/bus_ack/bus_rdata/bus_rvalid, one outstanding read at a time.
// Option: NEC_PREFETCH_BYTE_BUS_EN selects an 8-bit bus (one byte per fetch from bus_rdata[7:0]).
module nec_prefetch
  import nec_prefetch_pkg::*;
#(
  parameter int QUEUE_LIMIT = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ce,
  input  logic [15:0]                ps,
  input  logic                       flush,
  input  logic [15:0]                flush_pc,
  input  logic [15:0]                consume_pc,
  output logic [IPQ_DEPTH-1:0][7:0]  ipq,
  output logic [3:0]                 ipq_len,
  output logic                       bus_req,
  output logic [19:0]                bus_addr,
  input  logic                       bus_ack,
  input  logic [15:0]                bus_rdata,
  input  logic                       bus_rvalid
);
  localparam logic [4:0] LIMIT = 5'(QUEUE_LIMIT);
  prefetch_state_e state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic primed_q, primed_d, drop_q, drop_d, req_q, req_d;
  logic [19:0] addr_q, addr_d;
  logic [IPQ_DEPTH-1:0][7:0] ipq_q, ipq_d;
  logic [1:0] w;
  logic [2:0] idx, idx1;
  logic [7:0] lo;
  logic room;
`ifdef NEC_PREFETCH_BYTE_BUS_EN
  assign w  = 2'd1;
  assign lo = bus_rdata[7:0];
`else
  // an odd address returns its byte on the high lane of the word
  assign w  = fetch_pc_q[0] ? 2'd1 : 2'd2;
  assign lo = fetch_pc_q[0] ? bus_rdata[15:8] : bus_rdata[7:0];
`endif
  assign idx      = fetch_pc_q[2:0];
  assign idx1     = idx + 3'd1;
  assign ipq_len  = primed_q ? 4'(fetch_pc_q - consume_pc) : 4'd0;
  assign room     = ({1'b0, ipq_len} + {3'b0, w}) <= LIMIT;
  assign ipq      = ipq_q;
  assign bus_req  = req_q;
  assign bus_addr = addr_q;
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    primed_d   = primed_q;
    drop_d     = drop_q;
    req_d      = req_q;
    addr_d     = addr_q;
    ipq_d      = ipq_q;
    case (state_q)
      IDLE: if (primed_q && room) begin
        req_d   = 1'b1;
        addr_d  = phys_addr(ps, fetch_pc_q);
        state_d = REQ;
      end
      REQ: if (bus_ack) begin
        req_d   = 1'b0;
        drop_d  = 1'b0;
        state_d = drop_q ? DISCARD : WAIT_DATA;
      end
      WAIT_DATA: if (bus_rvalid) begin
        ipq_d[idx] = lo;
        if (w == 2'd2) ipq_d[idx1] = bus_rdata[15:8];
        fetch_pc_d = fetch_pc_q + {14'd0, w};
        state_d    = IDLE;
      end
      DISCARD: if (bus_rvalid) state_d = IDLE;
      default: ;
    endcase
    // a flush while the request is still unacked keeps the handshake alive and
    // marks the eventual data for discard
    if (flush) begin
      fetch_pc_d = flush_pc;
      primed_d   = 1'b1;
      ipq_d      = ipq_q;
      if (state_q == IDLE) begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
      if (state_q == REQ) begin
        state_d = bus_ack ? DISCARD : REQ;
        drop_d  = !bus_ack;
      end
      if (state_q == WAIT_DATA) state_d = bus_rvalid ? IDLE : DISCARD;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      primed_q   <= 1'b0;
      drop_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      ipq_q      <= '0;
    end else if (ce) begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      primed_q   <= primed_d;
      drop_q     <= drop_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      ipq_q      <= ipq_d;
    end
  end
endmodule

// File: tb/tb_nec_prefetch.sv
// tb_nec_prefetch: directed vector table, hand sequences and randomized run against a byte-address model
module tb_nec_prefetch;
  logic clk = 1'b0;
  logic reset_n, ce, flush, bus_ack, bus_rvalid, bus_req;
  logic [15:0] ps, flush_pc, consume_pc, bus_rdata;
  logic [7:0][7:0] ipq;
  logic [3:0] ipq_len;
  logic [19:0] bus_addr;
  int checks = 0, errors = 0;

  nec_prefetch dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .ps(ps), .flush(flush), .flush_pc(flush_pc),
    .consume_pc(consume_pc), .ipq(ipq), .ipq_len(ipq_len), .bus_req(bus_req),
    .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] phys(input logic [15:0] seg, input logic [15:0] off);
    int unsigned s;
    s = (32'(seg) * 16 + 32'(off)) % 32'h100000;
    return s[19:0];
  endfunction

  function automatic logic [7:0] mem(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[11:8]} ^ 8'h3C;
  endfunction

  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_req && n < 20);
    chk("req_seen", bus_req, 1);
  endtask

  task automatic xact(input logic [15:0] rd, output logic [19:0] a, output int n);
    wait_req(n);
    a = bus_addr;
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("req_drop", bus_req, 0);
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = rd;
    @(negedge clk);
    bus_rvalid = 1'b0;
  endtask

  task automatic fl(input logic [15:0] pc, input logic [15:0] seg);
    @(negedge clk);
    flush = 1'b1;
    flush_pc = pc;
    consume_pc = pc;
    ps = seg;
    @(negedge clk);
    flush = 1'b0;
  endtask

  typedef struct {
    logic        f;
    logic [15:0] fpc, seg, rd;
    logic [19:0] addr;
    logic [3:0]  len;
    logic [2:0]  idx;
    logic [7:0]  b;
    logic        full;
  } vec_t;

  initial begin
    vec_t tv[9];
    int n, resp_st, rvw, stall, wv, tw;
    logic [19:0] a, taddr;
    logic [15:0] mfp, ra;
    logic [3:0] el;
    logic live, mpr, ce_prev;
    tv[0] = '{1'b1, 16'h0100, 16'hF000, 16'hBBAA, 20'hF0100, 4'd2, 3'd0, 8'hAA, 1'b0};
    tv[1] = '{1'b0, 16'h0000, 16'hF000, 16'hDDCC, 20'hF0102, 4'd4, 3'd3, 8'hDD, 1'b0};
    tv[2] = '{1'b0, 16'h0000, 16'hF000, 16'hFFEE, 20'hF0104, 4'd6, 3'd5, 8'hFF, 1'b1};
    tv[3] = '{1'b1, 16'h0203, 16'hF000, 16'h3322, 20'hF0203, 4'd1, 3'd3, 8'h33, 1'b0};
    tv[4] = '{1'b0, 16'h0000, 16'hF000, 16'h5544, 20'hF0204, 4'd3, 3'd4, 8'h44, 1'b0};
    tv[5] = '{1'b0, 16'h0000, 16'hF000, 16'h7766, 20'hF0206, 4'd5, 3'd7, 8'h77, 1'b1};
    tv[6] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'hAB12, 20'h0FFEF, 4'd1, 3'd7, 8'hAB, 1'b0};
    tv[7] = '{1'b0, 16'h0000, 16'hFFFF, 16'h3456, 20'hFFFF0, 4'd3, 3'd1, 8'h34, 1'b0};
    tv[8] = '{1'b0, 16'h0000, 16'hFFFF, 16'h7788, 20'hFFFF2, 4'd5, 3'd2, 8'h88, 1'b1};
    reset_n = 1'b0; ce = 1'b1; flush = 1'b0; bus_ack = 1'b0; bus_rvalid = 1'b0;
    ps = 16'hF000; flush_pc = '0; consume_pc = 16'h0005; bus_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", bus_req, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_len", ipq_len, 0);
    chk("rst_ipq", ipq, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("unprimed_req", bus_req, 0);
    chk("unprimed_len", ipq_len, 0);
    for (int i = 0; i < 9; i++) begin
      if (tv[i].f) fl(tv[i].fpc, tv[i].seg);
      xact(tv[i].rd, a, n);
      if (tv[i].f) chk("req_latency", n, 1);
      chk("vec_addr", a, tv[i].addr);
      chk("vec_len", ipq_len, tv[i].len);
      chk("vec_byte", ipq[tv[i].idx], tv[i].b);
      if (tv[i].full) repeat (4) begin
        @(negedge clk);
        chk("full_hold", bus_req, 0);
      end
    end
    fl(16'h0100, 16'hF000);
    xact(16'hBBAA, a, n);
    xact(16'hDDCC, a, n);
    xact(16'hFFEE, a, n);
    chk("fill_b1", ipq[1], 8'hBB);
    chk("fill_b4", ipq[4], 8'hEE);
    consume_pc = 16'h0102;
    #1 chk("bp_len", ipq_len, 4);
    xact(16'h2211, a, n);
    chk("bp_latency", n, 1);
    chk("bp_addr", a, 20'hF0106);
    chk("bp_len_full", ipq_len, 6);
    chk("bp_b7", ipq[7], 8'h22);
    consume_pc = 16'h0104;
    wait_req(n);
    chk("inflight_addr", bus_addr, 20'hF0108);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0; flush = 1'b1; flush_pc = 16'h0500; consume_pc = 16'h0500;
    @(negedge clk);
    flush = 1'b0; bus_rvalid = 1'b1; bus_rdata = 16'h1234;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("inflight_len", ipq_len, 0);
    chk("inflight_b0", ipq[0], 8'hAA);
    chk("inflight_b1", ipq[1], 8'hBB);
    xact(16'h6655, a, n);
    chk("inflight_next", a, 20'hF0500);
    chk("inflight_fill", ipq_len, 2);
    wait_req(n);
    chk("rv_addr", bus_addr, 20'hF0502);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 16'h9999; flush = 1'b1; flush_pc = 16'h0600; consume_pc = 16'h0600;
    @(negedge clk);
    bus_rvalid = 1'b0; flush = 1'b0;
    chk("rvflush_len", ipq_len, 0);
    chk("rvflush_b2", ipq[2], 8'hCC);
    chk("rvflush_b3", ipq[3], 8'hDD);
    wait_req(n);
    chk("ackflush_addr", bus_addr, 20'hF0600);
    bus_ack = 1'b1; flush = 1'b1; flush_pc = 16'h0700; consume_pc = 16'h0700;
    @(negedge clk);
    bus_ack = 1'b0; flush = 1'b0;
    chk("ackflush_req", bus_req, 0);
    @(negedge clk);
    chk("discard_req", bus_req, 0);
    chk("discard_len", ipq_len, 0);
    bus_rvalid = 1'b1; bus_rdata = 16'h7777;
    @(negedge clk);
    bus_rvalid = 1'b0;
    xact(16'h8899, a, n);
    chk("ackflush_next", a, 20'hF0700);
    chk("ackflush_len", ipq_len, 2);
    chk("ackflush_b0", ipq[0], 8'h99);
    chk("ackflush_b1", ipq[1], 8'h88);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rerst_req", bus_req, 0);
    mpr = 1'b0; live = 1'b0; resp_st = 0; rvw = 0; stall = 0; mfp = '0; taddr = '0; ce_prev = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      el = mpr ? 4'(mfp - consume_pc) : 4'd0;
      chk("r_len", ipq_len, el);
      for (int i = 0; i < int'(el); i++) begin
        ra = consume_pc + 16'(i);
        chk("r_byte", ipq[ra[2:0]], mem(phys(ps, ra)));
      end
`ifdef NEC_PREFETCH_BYTE_BUS_EN
      wv = 1;
`else
      wv = mfp[0] ? 1 : 2;
`endif
      if (resp_st == 0 && bus_req) begin
        chk("r_addr", bus_addr, phys(ps, mfp));
        chk("r_room", int'(el) + wv <= 6, 1);
        taddr = bus_addr; live = 1'b1; resp_st = 1; stall = 0;
      end else if (resp_st == 1) chk("r_hold", {bus_req, bus_addr}, {1'b1, taddr});
      else chk("r_idle", bus_req, 0);
      if (resp_st == 0 && !bus_req && mpr && ce_prev && int'(el) + wv <= 6) stall++;
      if (stall > 3) begin
        chk("r_stall", stall, 3);
        stall = 0;
      end
      ce = ($urandom % 8) != 0;
      ce_prev = ce;
      bus_ack = 1'b0; bus_rvalid = 1'b0; flush = 1'b0;
      if (ce) begin
        if (!mpr || $urandom % 50 == 0) begin
          flush = 1'b1;
          flush_pc = ($urandom % 4 == 0) ? 16'hFFF8 + 16'($urandom % 8) : 16'($urandom);
          if ($urandom % 4 == 0) ps = 16'($urandom);
          consume_pc = flush_pc;
        end else if ($urandom % 3 == 0) consume_pc = consume_pc + 16'($urandom_range(32'(el)));
        if (resp_st == 1 && $urandom % 2 == 1) bus_ack = 1'b1;
        else if (resp_st == 2) begin
          if (rvw == 0) begin
            bus_rvalid = 1'b1;
`ifdef NEC_PREFETCH_BYTE_BUS_EN
            bus_rdata = {8'($urandom), mem(taddr)};
            tw = 1;
`else
            bus_rdata = taddr[0] ? {mem(taddr), 8'($urandom)} : {mem(taddr + 20'd1), mem(taddr)};
            tw = taddr[0] ? 1 : 2;
`endif
            resp_st = 0;
            if (live && !flush) mfp = mfp + 16'(tw);
          end else rvw--;
        end
        if (bus_ack) begin
          resp_st = 2;
          rvw = $urandom % 3;
        end
        if (flush) begin
          mfp = flush_pc; mpr = 1'b1; live = 1'b0;
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nec_prefetch.md
Name: nec_prefetch

Overview:
- Instruction prefetch queue feeding nec_decode.
- Fetches code bytes from PS:fetch_pc over the CPU bus into an 8-entry byte ring.
- Presents the ring as ipq[8]/ipq_len. The decoder indexes the ring by its own pc[2:0].
- Restarts from a new address on flush, which is asserted together with the decoder's set_pc.

Parameters:
- QUEUE_LIMIT, 6: maximum valid bytes held. Legal range 2..8. The ipq array is always 8 entries.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; all state updates gated by ce
- ps  in  16  code segment register
- flush  in  1  discard queue and restart at flush_pc
- flush_pc  in  16  restart offset
- consume_pc  in  16  decoder pc (the next byte the decoder will read)
- ipq  out  8x8  byte ring; entry k holds the byte whose address has low bits k
- ipq_len  out  4  valid bytes starting at consume_pc
- bus_req  out  1  fetch request
- bus_addr  out  20  physical address, (ps<<4)+fetch_pc, 20-bit wrap
- bus_ack  in  1  request accepted this cycle
- bus_rdata  in  16  read data
- bus_rvalid  in  1  read data valid; one pulse per accepted request

Behaviour:
- Reset values: fetch_pc=0, primed=0, ipq all 0, ipq_len=0, bus_req=0, bus_addr=0, state=IDLE.
- ipq_len:
  - 0 while primed=0.
  - Otherwise fetch_pc-consume_pc as a 16-bit subtract, truncated to 4 bits. This is combinational.
  - The decoder never advances consume_pc past fetch_pc, so the value is always 0..QUEUE_LIMIT.
- At most one transaction is outstanding.
- Word size w:
  - w=2 if fetch_pc[0]=0, otherwise w=1.
  - For odd fetch_pc only bus_rdata[15:8] is used, and bus_addr carries the odd address.
- State machine: IDLE, REQ, WAIT_DATA, DISCARD.
  - IDLE: if primed and ipq_len+w <= QUEUE_LIMIT, drive bus_req=1 and bus_addr; go to REQ.
  - REQ: hold bus_req and bus_addr stable until bus_ack. On ack: bus_req=0; go to WAIT_DATA, or to DISCARD if a flush occurred while in REQ.
  - WAIT_DATA: on bus_rvalid, write w bytes to ipq[fetch_pc[2:0]] and ipq[fetch_pc[2:0]+1], with 3-bit wrap. Then fetch_pc += w and go to IDLE.
  - DISCARD: on bus_rvalid, drop the data and go to IDLE.
- Request latency: first bus_req appears one ce cycle after flush. Fill: data is visible in ipq/ipq_len on the cycle after bus_rvalid.
- Flush (highest priority), in any state:
  - fetch_pc <= flush_pc and primed <= 1.
  - REQ or WAIT_DATA go to DISCARD; IDLE stays IDLE. The return of an in-flight request is never written.
  - Flush in the same cycle as bus_rvalid: data dropped, state goes to IDLE.
  - Flush in the same cycle as bus_ack: state goes to DISCARD.
- Odd wrap: fetch_pc=16'hFFFF fetches 1 byte, then fetch_pc=0000. bus_addr wraps mod 2^20.
- Consumer advance and a fill in the same cycle are both honoured; ipq_len reflects both next cycle.
- A reset mid-transaction abandons it. The bus is responsible for suppressing a late rvalid.

Optional Feature:
- Macro: NEC_PREFETCH_BYTE_BUS_EN.
- Defined: 8-bit bus (V20 mode). w is always 1 and only bus_rdata[7:0] is used, for even and odd addresses alike.
- Undefined: 16-bit word fetch with the odd-alignment rule above.

Decomposition:
- types package:
  - prefetch_state_e (IDLE, REQ, WAIT_DATA, DISCARD).
  - Constant IPQ_DEPTH=8, shared with nec_decode.
- No sub-module: the ring write and the length calculation are small and stay inline.

Test Plan:
- Basic fill:
  - Stimulus: reset; flush_pc=0100, ps=F000, consume_pc=0100; bus acks next cycle with rvalid 2 cycles later, rdata=BBAA then DDCC then FFEE.
  - Required: bus_addr F0100, F0102, F0104. ipq[0]=AA, ipq[1]=BB, ... ipq[5]=FF. ipq_len stops at 6 and bus_req stays low.
- Odd start:
  - Stimulus: flush_pc=0203.
  - Required: first bus_addr F0203, one byte taken from rdata[15:8] into ipq[3]. Next bus_addr is F0204 with a word fetch.
- Back-pressure:
  - Stimulus: queue full at 6, then consume_pc += 2.
  - Required: a new request is issued the next cycle; ipq_len returns to 6 after the fill.
- Flush in flight:
  - Stimulus: flush_pc=0500 while in WAIT_DATA, then rvalid with 1234.
  - Required: 1234 is not written and ipq_len=0. The next request is to F0500.
- Simultaneous events:
  - Stimulus: flush coincident with bus_rvalid; separately, flush coincident with bus_ack.
  - Required: data dropped in the first case. DISCARD is entered in the second, and exactly one rvalid is dropped.
- Wrap:
  - Stimulus: ps=FFFF, flush_pc=FFFF.
  - Required: bus_addr 0FFEF with a one-byte fetch, then fetch_pc=0000 and bus_addr=FFFF0. ipq_len is computed correctly across the 16-bit wrap.
